// File: rtl/stream_map_addk.sv
// Session-based stream kernel: adds ADDEND to LEN elements through a DEPTH-stage elastic pipeline.
// Optional feature macro STREAM_MAP_SAT_EN: saturating add plus sticky sat_seen output.
module stream_map_addk #(
    parameter int          WIDTH  = 8,
    parameter logic [63:0] ADDEND = 64'd1,
    parameter int          DEPTH  = 2,
    parameter int          LENW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LENW-1:0]  len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LENW-1:0]  out_count,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic [WIDTH-1:0] sOut,
    output logic             sOut_valid,
`ifdef STREAM_MAP_SAT_EN
    input  logic             sOut_ready,
    output logic             sat_seen
`else
    input  logic             sOut_ready
`endif
);

    localparam logic [WIDTH-1:0] K = ADDEND[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LENW-1:0]  r_remaining;
    logic [LENW-1:0]  r_emitted;
    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_stage0;
    logic             w_start;
    logic             w_in_fire;
    logic             w_out_fire;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_count  = r_emitted;
    assign sOut       = r_data[DEPTH-1];
    assign sOut_valid = r_vld[DEPTH-1];
    assign sIn_ready  = (r_state == S_RUN) && w_load[0];

    assign w_start    = in_valid && in_ready;
    assign w_in_fire  = sIn_valid && sIn_ready;
    assign w_out_fire = sOut_valid && sOut_ready;

    // A stage may load if it or any stage downstream of it holds a bubble,
    // or the whole chain is full and the sink is taking the head element.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_load[i] = sOut_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!r_vld[j]) begin
                    w_load[i] = 1'b1;
                end
            end
        end
    end

`ifdef STREAM_MAP_SAT_EN
    logic [WIDTH:0] w_sum;
    logic           r_sat_seen;

    assign w_sum    = {1'b0, sIn} + {1'b0, K};
    assign w_stage0 = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign sat_seen = r_sat_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_seen <= 1'b0;
        end else if (w_start) begin
            r_sat_seen <= 1'b0;
        end else if (w_in_fire && w_sum[WIDTH]) begin
            r_sat_seen <= 1'b1;
        end
    end
`else
    assign w_stage0 = sIn + K;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_in_fire && r_remaining == LENW'(1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_vld == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_emitted   <= '0;
        end else begin
            if (w_start) begin
                r_remaining <= len;
                r_emitted   <= '0;
            end else begin
                if (w_in_fire) begin
                    r_remaining <= r_remaining - LENW'(1);
                end
                if (w_out_fire && r_emitted != '1) begin
                    r_emitted <= r_emitted + LENW'(1);
                end
            end
        end
    end

    // Stage 0 applies the addend; later stages only move data forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0]  <= w_in_fire;
                r_data[0] <= w_stage0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_vld[i]  <= r_vld[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_map_addk.sv
// Directed bench for stream_map_addk at default parameters.
// Define STREAM_MAP_SAT_EN for both RTL and bench to check the saturating variant.
module tb_stream_map_addk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_count;
    logic [7:0]  sIn = '0;
    logic        sIn_valid = 1'b0;
    logic        sIn_ready;
    logic [7:0]  sOut;
    logic        sOut_valid;
    logic        sOut_ready = 1'b0;
`ifdef STREAM_MAP_SAT_EN
    logic        sat_seen;
`endif

    int n_chk = 0;
    int n_fail = 0;

    stream_map_addk dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .len        (len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .sIn        (sIn),
        .sIn_valid  (sIn_valid),
        .sIn_ready  (sIn_ready),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
`ifdef STREAM_MAP_SAT_EN
        .sOut_ready (sOut_ready),
        .sat_seen   (sat_seen)
`else
        .sOut_ready (sOut_ready)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        bit              bp;
        bit              excess;
        logic [7:0][7:0] d;
        logic [7:0][7:0] e;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   ii;
        int   oi;
        int   c_in;
        int   c_out;
        int   c_done;
        int   bad_ready;
        bit   seen_ready;
        bit   seen_drop;
        bit   stall;
        logic [7:0] prev_d;
        ii = 0; oi = 0; c_in = -1; c_out = -1; c_done = -1;
        bad_ready = 0; seen_ready = 0; seen_drop = 0; stall = 0; prev_d = '0;

        @(negedge clk);
        in_valid = 1'b1;
        len = 16'(v.n);
        #1;
        chk("start_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;

        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            sOut_ready = v.bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            sIn_valid  = v.excess ? 1'b1 : (ii < v.n);
            sIn        = (ii < 8) ? v.d[ii] : 8'hAA;
            #1;
            if (out_valid) begin
                c_done = c;
                break;
            end
            if (stall) begin
                chk("stall_hold", {55'd0, sOut_valid, sOut}, {55'd0, 1'b1, prev_d});
            end
            stall  = sOut_valid && !sOut_ready;
            prev_d = sOut;
            if (sIn_ready) seen_ready = 1'b1;
            if (sIn_ready && ii >= v.n) bad_ready++;
            if (!sIn_ready && ii > 0 && ii < v.n) seen_drop = 1'b1;
            if (sOut_valid && c_out < 0) c_out = c;
            if (sIn_valid && sIn_ready) begin
                if (ii == 0) c_in = c;
                ii++;
            end
            if (sOut_valid && sOut_ready) begin
                if (oi < 8) chk("sout_data", 64'(sOut), 64'(v.e[oi]));
                oi++;
            end
        end

        chk("done_reached", 64'(c_done >= 0), 64'd1);
        chk("in_count", 64'(ii), 64'(v.n));
        chk("out_elems", 64'(oi), 64'(v.n));
        chk("out_count", 64'(out_count), 64'(v.n));
        chk("excess_ready", 64'(bad_ready), 64'd0);
        if (v.n == 0) begin
            chk("len0_done_cycle", 64'(c_done), 64'd0);
            chk("len0_no_ready", 64'(seen_ready), 64'd0);
        end else begin
            chk("latency", 64'(c_out - c_in), 64'd2);
        end
        if (v.bp) chk("bp_ready_drop", 64'(seen_drop), 64'd1);
`ifdef STREAM_MAP_SAT_EN
        chk("sat_seen", 64'(sat_seen), 64'(v.n == 2 && v.d[0] == 8'd255));
`endif

        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("back_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        if (v.excess) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                chk("idle_no_sin_ready", 64'(sIn_ready), 64'd0);
            end
        end
        sIn_valid = 1'b0;
    endtask

    initial begin
        vec_t r;

        vecs[0] = '{n: 4, bp: 0, excess: 0, d: '0, e: '0};
        vecs[0].d[0] = 8'd10; vecs[0].d[1] = 8'd11;
        vecs[0].d[2] = 8'd12; vecs[0].d[3] = 8'd13;
        vecs[0].e[0] = 8'd11; vecs[0].e[1] = 8'd12;
        vecs[0].e[2] = 8'd13; vecs[0].e[3] = 8'd14;

        vecs[1] = '{n: 2, bp: 0, excess: 0, d: '0, e: '0};
        vecs[1].d[0] = 8'd255; vecs[1].d[1] = 8'd254;
`ifdef STREAM_MAP_SAT_EN
        vecs[1].e[0] = 8'd255; vecs[1].e[1] = 8'd255;
`else
        vecs[1].e[0] = 8'd0;   vecs[1].e[1] = 8'd255;
`endif

        vecs[2] = '{n: 8, bp: 1, excess: 0, d: '0, e: '0};
        vecs[2].d[0] = 8'd100; vecs[2].e[0] = 8'd101;
        vecs[2].d[1] = 8'd200; vecs[2].e[1] = 8'd201;
        vecs[2].d[2] = 8'd3;   vecs[2].e[2] = 8'd4;
        vecs[2].d[3] = 8'd50;  vecs[2].e[3] = 8'd51;
        vecs[2].d[4] = 8'd0;   vecs[2].e[4] = 8'd1;
        vecs[2].d[5] = 8'd254; vecs[2].e[5] = 8'd255;
        vecs[2].d[6] = 8'd77;  vecs[2].e[6] = 8'd78;
        vecs[2].d[7] = 8'd9;   vecs[2].e[7] = 8'd10;

        vecs[3] = '{n: 0, bp: 0, excess: 0, d: '0, e: '0};

        vecs[4] = '{n: 3, bp: 0, excess: 1, d: '0, e: '0};
        vecs[4].d[0] = 8'd5; vecs[4].d[1] = 8'd6; vecs[4].d[2] = 8'd7;
        vecs[4].d[3] = 8'd8; vecs[4].d[4] = 8'd9;
        vecs[4].e[0] = 8'd6; vecs[4].e[1] = 8'd7; vecs[4].e[2] = 8'd8;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outs", {60'd0, out_valid, sIn_ready, sOut_valid, 1'b0},
            64'd0);
        chk("rst_sout", 64'(sOut), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            run_vec(vecs[t]);
        end

        // Reset with two elements held in flight.
        @(negedge clk);
        in_valid = 1'b1;
        len = 16'd5;
        sOut_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sIn_valid = 1'b1;
            sIn = 8'(20 + k);
            #1;
            chk("mid_accept", 64'(sIn_ready), 64'd1);
            @(negedge clk);
        end
        sIn_valid = 1'b0;
        #1;
        chk("mid_full", 64'(sOut_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_flush", {62'd0, sOut_valid, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        sOut_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst", {61'd0, sOut_valid, in_ready, out_valid}, 64'd2);
        end

        r = '{n: 1, bp: 0, excess: 0, d: '0, e: '0};
        r.d[0] = 8'd7;
        r.e[0] = 8'd8;
        run_vec(r);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
